// File: rtl/mv_layer_sequencer.sv
// Purpose: steps a matrix-vector engine through up to MAX_LAYERS layers, flipping the x/y ping-pong buffer between layers.
// Latency: go sampled at edge t raises mv_start from t+1; mv_done seen at edge u drops it from u+1; gap between layers is 1 cycle plus the engine's done-clear time.
// Backpressure: level handshake with the engine; a per-phase watchdog bounds each RUN/REL wait, and abort ends the run early.
module mv_layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LOG_MAX    = 2,
  parameter int TIMEOUT_W  = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ps_control,
  input  logic [LOG_MAX:0]   cfg_num_layers,
  output logic [31:0]        pl_status,
  output logic               mv_start,
  input  logic               mv_done,
  output logic               buf_sel,
  output logic [LOG_MAX-1:0] layer_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_REL,
    S_NEXT,
    S_DONE,
    S_ERR,
    S_ABORT
  } state_t;

  localparam logic [LOG_MAX:0]   MAX_N    = (LOG_MAX+1)'(MAX_LAYERS);
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = '1;

  state_t               state;
  logic [LOG_MAX-1:0]   layer_q;
  logic [LOG_MAX:0]     num_q;
  logic                 buf_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 timeout_q;
  logic                 aborted_q;

  logic                 go;
  logic                 abort_req;
  logic [LOG_MAX:0]     n_clamped;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 wd_expire;
  logic                 last_hit;
  logic                 busy;
  logic                 unused_ctrl;

  assign go          = ps_control[0];
  assign abort_req   = ps_control[1];
  assign unused_ctrl = ^ps_control[31:2];

  // Layer count clamp, watchdog expiry and last-layer detection
  always_comb begin
    n_clamped = (cfg_num_layers > MAX_N) ? MAX_N : cfg_num_layers;
    wd_inc    = wd_q + TIMEOUT_W'(1);
    wd_expire = (wd_inc == WD_LIMIT);
    last_hit  = ({1'b0, layer_q} == (num_q - (LOG_MAX+1)'(1)));
    busy      = (state == S_RUN) || (state == S_REL) || (state == S_NEXT);
  end

  // Output decode straight from registered state; no extra pipeline stage
  always_comb begin
    mv_start  = (state == S_RUN);
    buf_sel   = buf_q;
    layer_idx = layer_q;
    pl_status = {16'h0000, {(8-LOG_MAX){1'b0}}, layer_q, 4'h0,
                 aborted_q, timeout_q, busy, (state == S_DONE)};
  end

  // Sequencer: abort beats timeout, timeout beats an engine handshake edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      layer_q   <= '0;
      num_q     <= '0;
      buf_q     <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            if (n_clamped == '0) begin
              state <= S_DONE;
            end else begin
              num_q   <= n_clamped;
              layer_q <= '0;
              buf_q   <= 1'b0;
              wd_q    <= '0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort_req) begin
            aborted_q <= 1'b1;
            state     <= S_ABORT;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
            state     <= S_ERR;
          end else if (mv_done) begin
            wd_q  <= '0;
            state <= S_REL;
          end else begin
            wd_q <= wd_inc;
          end
        end
        S_REL: begin
          if (abort_req) begin
            aborted_q <= 1'b1;
            state     <= S_ABORT;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
            state     <= S_ERR;
          end else if (!mv_done) begin
            state <= S_NEXT;
          end else begin
            wd_q <= wd_inc;
          end
        end
        S_NEXT: begin
          if (abort_req) begin
            aborted_q <= 1'b1;
            state     <= S_ABORT;
          end else if (last_hit) begin
            state <= S_DONE;
          end else begin
            layer_q <= layer_q + LOG_MAX'(1);
            buf_q   <= ~buf_q;
            wd_q    <= '0;
            state   <= S_RUN;
          end
        end
        S_DONE: begin
          if (!go) state <= S_IDLE;
        end
        S_ERR, S_ABORT: begin
          if (!mv_done && !go) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_layer_sequencer.sv
module tb_mv_layer_sequencer;

  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_control;
  logic [2:0]  cfg;
  logic        mv_done;
  logic [31:0] pl_status;
  logic        mv_start;
  logic        buf_sel;
  logic [1:0]  layer_idx;

  logic [31:0] ps_control_t;
  logic [2:0]  cfg_t;
  logic        mv_done_t;
  logic [31:0] pl_status_t;
  logic        mv_start_t;
  logic        buf_sel_t;
  logic [1:0]  layer_idx_t;

  int checks = 0;
  int errors = 0;

  int eng_lat = 1000000;
  int eng_hold = 1;
  int start_cnt = 0;
  int hold_cnt = 0;

  mv_layer_sequencer #(.MAX_LAYERS(4), .LOG_MAX(2), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .ps_control(ps_control), .cfg_num_layers(cfg),
    .pl_status(pl_status), .mv_start(mv_start), .mv_done(mv_done),
    .buf_sel(buf_sel), .layer_idx(layer_idx)
  );

  mv_layer_sequencer #(.MAX_LAYERS(4), .LOG_MAX(2), .TIMEOUT_W(4)) dut_t (
    .clk(clk), .reset(reset), .ps_control(ps_control_t), .cfg_num_layers(cfg_t),
    .pl_status(pl_status_t), .mv_start(mv_start_t), .mv_done(mv_done_t),
    .buf_sel(buf_sel_t), .layer_idx(layer_idx_t)
  );

  always #5 clk = ~clk;

  // One clock; sample after the edge, then let the engine model react for the next edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (mv_start) begin
      hold_cnt = 0;
      start_cnt++;
      if (start_cnt >= eng_lat) mv_done = 1'b1;
    end else begin
      start_cnt = 0;
      if (mv_done) begin
        hold_cnt++;
        if (hold_cnt >= eng_hold) begin
          mv_done  = 1'b0;
          hold_cnt = 0;
        end
      end
    end
  endtask

  task automatic eng_clear();
    start_cnt = 0;
    hold_cnt  = 0;
    mv_done   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps_control = '0; cfg = '0; mv_done = 1'b0;
    ps_control_t = '0; cfg_t = '0; mv_done_t = 1'b0;
    repeat (3) tick();
    checks++;
    if (pl_status !== 32'h0 || mv_start !== 1'b0 || layer_idx !== 2'd0 || buf_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset: status=%h start=%b idx=%0d buf=%b, want 0/0/0/0", pl_status, mv_start, layer_idx, buf_sel);
    end
    checks++;
    if (pl_status_t !== 32'h0 || mv_start_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_t: status=%h start=%b, want 0/0", pl_status_t, mv_start_t);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_layers();
    cfg = 3'd0; ps_control = 32'h1;
    tick();
    checks++;
    if (pl_status[3:0] !== 4'b0001 || mv_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_layers: status=%h start=%b, want done=1 start=0", pl_status, mv_start);
    end
    repeat (3) begin
      tick();
      checks++;
      if (mv_start !== 1'b0 || pl_status[0] !== 1'b1) begin
        errors++;
        $display("FAIL zero_hold: status=%h start=%b, want done held, start=0", pl_status, mv_start);
      end
    end
    ps_control = 32'h0;
    tick();
    checks++;
    if (pl_status[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL zero_release: status=%h, want low nibble 0", pl_status);
    end
  endtask

  task automatic test_stale_done();
    mv_done = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (mv_start !== 1'b0 || pl_status[1:0] !== 2'b00) begin
        errors++;
        $display("FAIL stale_done: status=%h start=%b, want idle", pl_status, mv_start);
      end
    end
    eng_clear();
    tick();
  endtask

  // Full run; expectations come from layer count, engine latency and hold time alone
  task automatic run_layers(input int n, input int lat, input int hold, input string name);
    int en, pulses, hi, lo, cyc;
    bit prev;
    en = (n > MAXL) ? MAXL : n;
    eng_clear();
    eng_lat = lat; eng_hold = hold;
    cfg = 3'(n); ps_control = 32'h1;
    pulses = 0; hi = 0; lo = 0; prev = 1'b0; cyc = 0;
    forever begin
      tick();
      cyc++;
      if (pl_status[0] === 1'b1 || cyc > 3000) break;
      if (mv_start) begin
        if (!prev) begin
          checks++;
          if (int'(layer_idx) !== pulses || buf_sel !== pulses[0] || pl_status[1] !== 1'b1 ||
              int'(pl_status[15:8]) !== pulses || (pulses > 0 && lo !== hold + 1)) begin
            errors++;
            $display("FAIL %s start%0d: idx=%0d buf=%b status=%h gap=%0d, want idx=%0d buf=%b gap=%0d",
                     name, pulses, layer_idx, buf_sel, pl_status, lo, pulses, pulses[0], hold + 1);
          end
          pulses++;
          hi = 0;
        end
        hi++;
      end else begin
        if (prev) begin
          checks++;
          if (hi !== lat) begin
            errors++;
            $display("FAIL %s pulse_len: got %0d want %0d", name, hi, lat);
          end
          lo = 0;
        end
        lo++;
      end
      prev = mv_start;
    end
    checks++;
    if (cyc > 3000) begin
      errors++;
      $display("FAIL %s timeout: no done within 3000 cycles", name);
    end
    checks++;
    if (pulses !== en || lo !== hold + 1) begin
      errors++;
      $display("FAIL %s count: pulses=%0d tail=%0d, want %0d/%0d", name, pulses, lo, en, hold + 1);
    end
    checks++;
    if (pl_status[3:0] !== 4'b0001 || mv_start !== 1'b0 || buf_sel !== ((en - 1) % 2 == 1)) begin
      errors++;
      $display("FAIL %s done_state: status=%h start=%b buf=%b, want nibble 1 start 0 buf %0d",
               name, pl_status, mv_start, buf_sel, (en - 1) % 2);
    end
    tick();
    checks++;
    if (pl_status[3:0] !== 4'b0001 || mv_start !== 1'b0) begin
      errors++;
      $display("FAIL %s done_hold: status=%h start=%b, want done held with go=1", name, pl_status, mv_start);
    end
    ps_control = 32'h0;
    tick();
    checks++;
    if (pl_status[3:0] !== 4'b0000 || mv_start !== 1'b0) begin
      errors++;
      $display("FAIL %s release: status=%h start=%b, want nibble 0", name, pl_status, mv_start);
    end
  endtask

  task automatic test_basic();
    run_layers(3, 50, 1, "basic");
  endtask

  task automatic test_done_hold();
    run_layers(2, 10, 5, "hold");
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 6; it++) begin
      run_layers($urandom_range(1, 7), $urandom_range(1, 20), $urandom_range(1, 6), "random");
    end
  endtask

  task automatic test_abort();
    int cyc;
    eng_clear();
    eng_lat = 40; eng_hold = 1;
    cfg = 3'd2; ps_control = 32'h1;
    repeat (42 + 10) tick();
    checks++;
    if (mv_start !== 1'b1 || layer_idx !== 2'd1) begin
      errors++;
      $display("FAIL abort_setup: start=%b idx=%0d, want 1/1", mv_start, layer_idx);
    end
    ps_control = 32'h3;
    tick();
    ps_control = 32'h1;
    checks++;
    if (mv_start !== 1'b0 || pl_status[3:0] !== 4'b1000 || pl_status[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL abort: start=%b status=%h, want start 0 status 0x108", mv_start, pl_status);
    end
    repeat (5) begin
      tick();
      checks++;
      if (mv_start !== 1'b0 || pl_status[3] !== 1'b1) begin
        errors++;
        $display("FAIL abort_hold: start=%b status=%h, want parked in abort", mv_start, pl_status);
      end
    end
    ps_control = 32'h0;
    tick();
    cfg = 3'd1; ps_control = 32'h1;
    tick();
    checks++;
    if (mv_start !== 1'b1 || pl_status[3] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rego: start=%b status=%h, want new run with flag cleared", mv_start, pl_status);
    end
    cyc = 0;
    while (pl_status[0] !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL abort_finish: run after abort never completed");
    end
    ps_control = 32'h0;
    tick();
  endtask

  // Abort at a random sample; busy/layer at that point follows from the layer period
  task automatic test_random_abort();
    for (int it = 0; it < 6; it++) begin
      int n, en, lat, hold, p, k, el;
      n = $urandom_range(1, 6);
      en = (n > MAXL) ? MAXL : n;
      lat = $urandom_range(2, 12);
      hold = $urandom_range(1, 4);
      p = lat + hold + 1;
      k = $urandom_range(1, en * p + 4);
      eng_clear();
      eng_lat = lat; eng_hold = hold;
      cfg = 3'(n); ps_control = 32'h1;
      repeat (k) tick();
      ps_control = 32'h3;
      tick();
      ps_control = 32'h1;
      checks++;
      if (k <= en * p) begin
        el = (k - 1) / p;
        if (mv_start !== 1'b0 || pl_status[3:0] !== 4'b1000 || int'(pl_status[15:8]) !== el) begin
          errors++;
          $display("FAIL rand_abort k=%0d: start=%b status=%h, want aborted at layer %0d", k, mv_start, pl_status, el);
        end
      end else begin
        if (mv_start !== 1'b0 || pl_status[3:0] !== 4'b0001) begin
          errors++;
          $display("FAIL rand_abort_done k=%0d: status=%h, want abort ignored in done", k, pl_status);
        end
      end
      ps_control = 32'h0;
      repeat (12) tick();
    end
  endtask

  task automatic test_timeout();
    int cnt;
    cfg_t = 3'd1; ps_control_t = 32'h1; mv_done_t = 1'b0;
    tick();
    cnt = 0;
    while (mv_start_t === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 15 || pl_status_t[2:0] !== 3'b100 || mv_start_t !== 1'b0) begin
      errors++;
      $display("FAIL timeout_run: run_cycles=%0d status=%h start=%b, want 15, timeout set", cnt, pl_status_t, mv_start_t);
    end
    ps_control_t = 32'h0;
    tick();
    ps_control_t = 32'h1;
    tick();
    checks++;
    if (mv_start_t !== 1'b1 || pl_status_t[2] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rego: start=%b status=%h, want restart with flag cleared", mv_start_t, pl_status_t);
    end
    mv_done_t = 1'b1;
    tick();
    cnt = 0;
    while (mv_start_t === 1'b0 && pl_status_t[1] === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 15 || pl_status_t[2:0] !== 3'b100) begin
      errors++;
      $display("FAIL timeout_rel: rel_cycles=%0d status=%h, want 15, timeout set", cnt, pl_status_t);
    end
    ps_control_t = 32'h0;
    repeat (3) tick();
    ps_control_t = 32'h1;
    tick();
    checks++;
    if (mv_start_t !== 1'b0) begin
      errors++;
      $display("FAIL timeout_wait_done: start=%b, want 0 while engine done still high", mv_start_t);
    end
    ps_control_t = 32'h0; mv_done_t = 1'b0;
    tick();
    ps_control_t = 32'h1;
    tick();
    checks++;
    if (mv_start_t !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: start=%b, want 1 after clean return to idle", mv_start_t);
    end
    ps_control_t = 32'h0;
  endtask

  task automatic test_reset_midrun();
    eng_clear();
    eng_lat = 30; eng_hold = 1;
    cfg = 3'd3; ps_control = 32'h1;
    repeat (2 * 32 + 6) tick();
    checks++;
    if (mv_start !== 1'b1 || layer_idx !== 2'd2) begin
      errors++;
      $display("FAIL reset_setup: start=%b idx=%0d, want 1/2", mv_start, layer_idx);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mv_start !== 1'b0 || pl_status !== 32'h0 || layer_idx !== 2'd0 || buf_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: start=%b status=%h idx=%0d buf=%b, want all 0", mv_start, pl_status, layer_idx, buf_sel);
    end
    reset = 1'b0; ps_control = 32'h0;
    eng_clear();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_zero_layers();
    test_stale_done();
    test_basic();
    test_done_hold();
    test_random_runs();
    test_abort();
    test_random_abort();
    test_timeout();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
